// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the memory stage
package mips_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_LO = 4'h3;
  localparam logic [3:0] BE_HI = 4'hC;
  localparam int MAX_WAIT_DEF = 16;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: request/acknowledge data-memory bus
interface mem_stage_ctrl_if;
  logic memReq, memWe, memAck;
  logic [31:0] memAddr, memWData, memRData;
  logic [3:0] memBe;
  modport master(output memReq, memWe, memAddr, memWData, memBe, input memAck, memRData);
  modport slave(input memReq, memWe, memAddr, memWData, memBe, output memAck, memRData);
endinterface

// File: rtl/load_extract.sv
// load_extract: halfword select with sign/zero extension
module load_extract (
  input  logic [31:0] rdata,
  input  logic        hi,
  input  logic        uns,
  output logic [31:0] data
);
  logic [15:0] h;
  assign h = hi ? rdata[31:16] : rdata[15:0];
  assign data = {{16{h[15] & ~uns}}, h};
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage controller with memory handshake, load extraction and timeout
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exWB,
  input  logic                    exMemtoReg,
  input  logic                    exMR,
  input  logic                    exMW,
  input  logic                    exBranch,
  input  logic                    exZero,
  input  logic                    exLoadHalf,
  input  logic                    exLoadHalfUnsigned,
  input  logic [31:0]             exAddResult,
  input  logic [31:0]             exALUResult,
  input  logic [31:0]             exReadData2,
  input  logic [4:0]              exWriteBack,
  mem_stage_ctrl_if.master        mem,
  output logic                    stall,
  output logic                    pcSrc,
  output logic [31:0]             branchTarget,
  output logic                    memErr,
  output logic                    wbRegWrite,
  output logic                    wbMemtoReg,
  output logic [31:0]             wbReadData,
  output logic [31:0]             wbALUResult,
  output logic [4:0]              wbWriteBack
);
  localparam int CW = $clog2(MAX_WAIT);
  state_t state, nxt;
  logic [CW-1:0] wait_cnt;
  logic access, half, illegal, pass, start, timeout, done, err_set;
  logic [3:0] be;
  logic [31:0] half_data, load_data;
  assign pcSrc = exBranch & exZero;
  assign branchTarget = exAddResult;
  assign access = exMR ^ exMW;
  assign half = exLoadHalf | exLoadHalfUnsigned;
  assign illegal = (exMR & exMW) | (access & (half ? (exMW | exALUResult[0]) : |exALUResult[1:0]));
  assign be = (exMW || !half) ? BE_WORD : (exALUResult[1] ? BE_HI : BE_LO);
  load_extract u_ext (
    .rdata(mem.memRData),
    .hi   (exALUResult[1]),
    .uns  (exLoadHalfUnsigned),
    .data (half_data)
  );
  assign load_data = half ? half_data : mem.memRData;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      mem.memReq <= 1'b0;
      mem.memWe <= 1'b0;
      mem.memAddr <= '0;
      mem.memWData <= '0;
      mem.memBe <= '0;
      memErr <= 1'b0;
      wbRegWrite <= 1'b0;
      wbMemtoReg <= 1'b0;
      wbReadData <= '0;
      wbALUResult <= '0;
      wbWriteBack <= '0;
    end else begin
      state <= nxt;
      wait_cnt <= (state == BUSY && !done) ? wait_cnt + 1'b1 : '0;
      mem.memReq <= start | (mem.memReq & ~done);
      if (start) begin
        mem.memWe <= exMW;
        mem.memAddr <= {exALUResult[31:2], 2'b00};
        mem.memWData <= exReadData2;
        mem.memBe <= be;
      end
      memErr <= memErr | err_set;
      wbRegWrite <= (pass & exWB) | (done & exWB & exMR);
      wbMemtoReg <= (pass | done) & exMemtoReg;
      // a timed-out access completes with zero data
      wbReadData <= (done && mem.memAck) ? load_data : '0;
      wbALUResult <= (pass || done) ? exALUResult : '0;
      wbWriteBack <= (pass || done) ? exWriteBack : '0;
    end
  end
  always_comb nxt = (state == IDLE) ? (start ? BUSY : IDLE) : (done ? IDLE : BUSY);
  always_comb begin
    pass = state == IDLE && !exMR && !exMW;
    start = state == IDLE && access && !illegal;
    timeout = state == BUSY && !mem.memAck && wait_cnt == CW'(MAX_WAIT - 1);
    done = state == BUSY && (mem.memAck || timeout);
    stall = (state == IDLE) ? start : !done;
    err_set = (state == IDLE) ? illegal : timeout;
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed plus randomized checks against a transaction-level model
module tb_mem_stage_ctrl;
  localparam int MW = 16;
  logic clk = 1'b0;
  logic rst;
  logic exWB, exMemtoReg, exMR, exMW, exBranch, exZero, exLoadHalf, exLoadHalfUnsigned;
  logic [31:0] exAddResult, exALUResult, exReadData2;
  logic [4:0] exWriteBack;
  logic stall, pcSrc, memErr, wbRegWrite, wbMemtoReg;
  logic [31:0] branchTarget, wbReadData, wbALUResult;
  logic [4:0] wbWriteBack;
  int n_chk = 0;
  int n_pass = 0;
  logic err_m;
  always #5 clk = ~clk;
  mem_stage_ctrl_if mif ();
  mem_stage_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .exWB(exWB), .exMemtoReg(exMemtoReg), .exMR(exMR), .exMW(exMW),
    .exBranch(exBranch), .exZero(exZero), .exLoadHalf(exLoadHalf),
    .exLoadHalfUnsigned(exLoadHalfUnsigned), .exAddResult(exAddResult),
    .exALUResult(exALUResult), .exReadData2(exReadData2), .exWriteBack(exWriteBack),
    .mem(mif.master), .stall(stall), .pcSrc(pcSrc), .branchTarget(branchTarget),
    .memErr(memErr), .wbRegWrite(wbRegWrite), .wbMemtoReg(wbMemtoReg),
    .wbReadData(wbReadData), .wbALUResult(wbALUResult), .wbWriteBack(wbWriteBack)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic hf, input logic uns);
    logic [31:0] h;
    if (!hf) return rd;
    h = addr[1] ? rd / 65536 : rd % 65536;
    return (uns || h < 32768) ? h : h + 32'hFFFF0000;
  endfunction
  task automatic set_op(input logic wb, m2r, mr, mw, br, z, lh, lhu,
                        input logic [31:0] alu, d2, tgt, input logic [4:0] wr);
    exWB = wb; exMemtoReg = m2r; exMR = mr; exMW = mw; exBranch = br; exZero = z;
    exLoadHalf = lh; exLoadHalfUnsigned = lhu; exALUResult = alu; exReadData2 = d2;
    exAddResult = tgt; exWriteBack = wr;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_memReq", mif.memReq, 0);
    check("rst_memWe", mif.memWe, 0);
    check("rst_memBe", mif.memBe, 0);
    check("rst_memAddr", mif.memAddr, 0);
    check("rst_memWData", mif.memWData, 0);
    check("rst_memErr", memErr, 0);
    check("rst_wbRegWrite", wbRegWrite, 0);
    check("rst_wbMemtoReg", wbMemtoReg, 0);
    check("rst_wbReadData", wbReadData, 0);
    check("rst_wbALUResult", wbALUResult, 0);
    check("rst_wbWriteBack", wbWriteBack, 0);
    @(negedge clk);
    rst = 1'b0;
    err_m = 1'b0;
  endtask
  // called at a negedge with the op already on the EX/MEM inputs; k<0 or k>=MW means no ack
  task automatic run(input int k, input logic [31:0] rdata, input bit stray);
    bit acc, hf, ill, ack, to_hit;
    int n_st;
    logic [3:0] exp_be;
    acc = exMR ^ exMW;
    hf = exLoadHalf || exLoadHalfUnsigned;
    ill = (exMR && exMW) || (acc && (hf ? (exMW || exALUResult[0]) : exALUResult[1:0] != 2'b00));
    exp_be = (exMW || !hf) ? 4'hF : (exALUResult[1] ? 4'hC : 4'h3);
    mif.memAck = stray;
    mif.memRData = $urandom;
    #1;
    check("pcSrc", pcSrc, exBranch && exZero);
    check("branchTarget", branchTarget, exAddResult);
    if (!acc || ill) begin
      check("pass_stall", stall, 0);
      @(posedge clk);
      #1;
      mif.memAck = 1'b0;
      if (ill) err_m = 1'b1;
      check("pass_wbRegWrite", wbRegWrite, ill ? 1'b0 : exWB);
      if (!ill) begin
        check("pass_wbMemtoReg", wbMemtoReg, exMemtoReg);
        check("pass_wbALUResult", wbALUResult, exALUResult);
        check("pass_wbWriteBack", wbWriteBack, exWriteBack);
        check("pass_wbReadData", wbReadData, 0);
      end
      check("pass_memReq", mif.memReq, 0);
      check("pass_memErr", memErr, err_m);
    end else begin
      check("idle_stall", stall, 1);
      @(posedge clk);
      n_st = 0;
      to_hit = 1'b0;
      for (int b = 0; b < MW; b++) begin
        @(negedge clk);
        ack = (b == k);
        mif.memAck = ack;
        mif.memRData = ack ? rdata : $urandom;
        to_hit = !ack && b == MW - 1;
        #1;
        if (stall) n_st++;
        check("busy_stall", stall, !(ack || to_hit));
        check("busy_memReq", mif.memReq, 1);
        if (b == 0) begin
          check("memAddr", mif.memAddr, {exALUResult[31:2], 2'b00});
          check("memBe", mif.memBe, exp_be);
          check("memWe", mif.memWe, exMW);
          check("memWData", mif.memWData, exReadData2);
        end
        if (ack || to_hit) break;
      end
      check("stall_cycles", n_st, to_hit ? MW - 1 : k);
      @(posedge clk);
      #1;
      mif.memAck = 1'b0;
      if (to_hit) err_m = 1'b1;
      check("done_memReq", mif.memReq, 0);
      check("done_wbRegWrite", wbRegWrite, exWB && exMR);
      check("done_wbALUResult", wbALUResult, exALUResult);
      check("done_wbWriteBack", wbWriteBack, exWriteBack);
      if (exMR) check("done_wbReadData", wbReadData,
                      to_hit ? 32'h0 : exp_load(rdata, exALUResult, hf, exLoadHalfUnsigned));
      check("done_memErr", memErr, err_m);
    end
    @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic wb, m2r, mr, mw, lh, lhu;
    logic [31:0] alu;
    int cat, k;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mif.memAck = 1'b0;
    mif.memRData = '0;
    err_m = 1'b0;
    do_reset();
    set_op(1, 0, 0, 0, 1, 1, 0, 0, 32'h1234, 0, 32'h40, 7);
    run(0, 0, 0);
    set_op(1, 1, 1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 3);
    run(3, 32'hDEADBEEF, 0);
    set_op(1, 1, 1, 0, 0, 0, 1, 0, 32'h102, 0, 0, 4);
    run(1, 32'h8001_0000, 0);
    set_op(1, 1, 1, 0, 0, 0, 0, 1, 32'h102, 0, 0, 5);
    run(1, 32'h8001_0000, 0);
    set_op(1, 0, 0, 1, 0, 0, 0, 0, 32'h200, 32'hCAFEF00D, 0, 6);
    run(0, 0, 0);
    set_op(1, 1, 1, 0, 0, 0, 0, 0, 32'h300, 0, 0, 8);
    run(-1, 32'h11111111, 0);
    set_op(1, 0, 0, 0, 0, 1, 0, 0, 32'h55, 0, 0, 9);
    run(0, 0, 1);
    do_reset();
    set_op(1, 1, 1, 0, 0, 0, 0, 0, 32'h101, 0, 0, 10);
    run(0, 0, 0);
    set_op(1, 1, 1, 0, 0, 0, 0, 0, 32'h400, 0, 0, 11);
    @(posedge clk);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cat = $urandom_range(0, 5);
      wb = 1'($urandom); m2r = 1'($urandom); alu = $urandom;
      mr = 0; mw = 0; lh = 0; lhu = 0;
      if (cat == 2) begin mr = 1; alu[1:0] = 0; end
      if (cat == 3) begin mr = 1; alu[0] = 0; lh = 1'($urandom); lhu = !lh || 1'($urandom); end
      if (cat == 4) begin mw = 1; alu[1:0] = 0; end
      if (cat == 5) begin
        mr = 1'($urandom); mw = 1'($urandom); lh = 1'($urandom); lhu = 1'($urandom);
        if (!mr && !mw) mr = 1;
      end
      k = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      set_op(wb, m2r, mr, mw, 1'($urandom), 1'($urandom), lh, lhu, alu, $urandom, $urandom,
             5'($urandom));
      run(k, $urandom, 1'($urandom));
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
